// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Purpose: oversampling UART receiver (DATA_BITS, optional parity, 1 stop) feeding a receive FIFO.
// Latency: word is pushed on the mid-stop sample; pops return rd_data/rd_valid one clk after rd_en.
// Backpressure: none on the line; a good frame arriving while the FIFO is full is dropped with an overflow pulse.
//
// Ports: clk/rst (async active-high), rx (raw serial line, idle high),
//        rd_en -> rd_data/rd_valid (pop), empty/full/count (occupancy),
//        frame_err/parity_err/overflow (one-clk status pulses).
// Optional build macro: UART_RX_MAJORITY_VOTE_EN -- 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);

  localparam int DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision is taken on the last of the three vote samples.
  localparam int DEC_TICK = OVERSAMPLE / 2;
`else
  localparam int DEC_TICK = OVERSAMPLE / 2 - 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 arm_q, arm_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overflow_q, overflow_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];

  logic rx_s, tick, dec, wrap, bit_val, push_req, do_push, do_pop;

  assign rx_s = sync2_q;
  assign tick = (state_q != S_IDLE) && (div_cnt_q == DIV_W'(DIV - 1));
  assign dec  = tick && (tick_cnt_q == TW'(DEC_TICK));
  assign wrap = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q, vote_d;
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

  always_comb begin
    vote_d = vote_q;
    if (tick && (tick_cnt_q == TW'(DEC_TICK - 2) || tick_cnt_q == TW'(DEC_TICK - 1)))
      vote_d = {vote_q[0], rx_s};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vote_q <= 2'b11;
    else     vote_q <= vote_d;
  end
`else
  assign bit_val = rx_s;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // arm_q blocks a line still low after a bad stop bit from looking like a new start.
      S_IDLE:   if (arm_q && !rx_s) state_d = S_START;
      S_START:  if (dec && bit_val) state_d = S_IDLE;
                else if (wrap)      state_d = S_DATA;
      S_DATA:   if (wrap && bit_cnt_q == BW'(DATA_BITS - 1))
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (wrap) state_d = S_STOP;
      S_STOP:   if (dec)  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: frame verdict on the stop-bit decision
  always_comb begin
    push_req     = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (state_q == S_STOP && dec) begin
      if (!bit_val)       frame_err_d  = 1'b1;
      else if (par_err_q) parity_err_d = 1'b1;
      else                push_req     = 1'b1;
    end
  end

  // Receiver datapath
  always_comb begin
    div_cnt_d  = div_cnt_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    arm_d      = arm_q;
    // Divider and tick counter sit at zero in IDLE, so they restart exactly on the falling edge.
    if (state_q == S_IDLE) begin
      div_cnt_d  = '0;
      tick_cnt_d = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      if (tick) tick_cnt_d = wrap ? '0 : tick_cnt_q + TW'(1);
    end
    if (state_q != S_DATA) bit_cnt_d = '0;
    else if (wrap)         bit_cnt_d = bit_cnt_q + BW'(1);
    if (state_q == S_DATA && dec) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
    if (state_q == S_START) par_err_d = 1'b0;
    // Odd parity expects an overall XOR of 1, even parity an XOR of 0.
    else if (state_q == S_PARITY && dec) par_err_d = (^{shift_q, bit_val}) ^ (PARITY == 1);
    if (state_q == S_STOP && dec)        arm_d = 1'b0;
    else if (state_q == S_IDLE && rx_s)  arm_d = 1'b1;
  end

  // FIFO control; a pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  always_comb begin
    do_pop     = rd_en && (count_q != '0);
    do_push    = push_req && ((count_q != (AW+1)'(FIFO_DEPTH)) || do_pop);
    overflow_d = push_req && !do_push;
    count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_data_d  = do_pop  ? fifo_mem[rd_ptr_q] : rd_data_q;
    rd_valid_d = do_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      div_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      arm_q        <= 1'b1;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      div_cnt_q    <= div_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      arm_q        <= arm_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= shift_q;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
  assign count      = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Purpose: directed bench for uart_rx_fifo (default, even-parity and 4-deep instances).
// Latency: frames driven at 8680 ns per bit on a 50 MHz clock; pops checked one clk after rd_en.
// Backpressure: depth-4 instance is filled past capacity to provoke overflow.
module tb_uart_rx_fifo;

  localparam int BIT_NS = 8680;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_l    [3];
  logic rd_en_l [3];

  always #10 clk = ~clk;

  logic [7:0] a_rd_data, b_rd_data, c_rd_data;
  logic       a_rd_valid, b_rd_valid, c_rd_valid;
  logic       a_empty, b_empty, c_empty;
  logic       a_full, b_full, c_full;
  logic [4:0] a_count, b_count;
  logic [2:0] c_count;
  logic       a_fe, b_fe, c_fe, a_pe, b_pe, c_pe, a_ov, b_ov, c_ov;

  uart_rx_fifo u_dut (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .rd_en(rd_en_l[0]),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .empty(a_empty), .full(a_full),
    .count(a_count), .frame_err(a_fe), .parity_err(a_pe), .overflow(a_ov));

  uart_rx_fifo #(.PARITY(2)) u_par (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .rd_en(rd_en_l[1]),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .empty(b_empty), .full(b_full),
    .count(b_count), .frame_err(b_fe), .parity_err(b_pe), .overflow(b_ov));

  uart_rx_fifo #(.FIFO_DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .rd_en(rd_en_l[2]),
    .rd_data(c_rd_data), .rd_valid(c_rd_valid), .empty(c_empty), .full(c_full),
    .count(c_count), .frame_err(c_fe), .parity_err(c_pe), .overflow(c_ov));

  // Pulse counters, sampled on the falling edge.
  int a_fe_n = 0, a_pe_n = 0, a_ov_n = 0, b_fe_n = 0, b_pe_n = 0, c_ov_n = 0;
  always @(negedge clk) begin
    if (a_fe) a_fe_n++;
    if (a_pe) a_pe_n++;
    if (a_ov) a_ov_n++;
    if (b_fe) b_fe_n++;
    if (b_pe) b_pe_n++;
    if (c_ov) c_ov_n++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int w, input logic v);
    rx_l[w] = v;
    #(BIT_NS);
  endtask

  // par < 0 means no parity bit on the wire.
  task automatic send_frame(input int w, input logic [7:0] d, input int par, input logic stop);
    drive_bit(w, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
    if (par >= 0) drive_bit(w, par[0]);
    drive_bit(w, stop);
    drive_bit(w, 1'b1);
  endtask

  task automatic pop(input int w, output logic [7:0] d, output logic v, output logic v_next);
    @(negedge clk);
    rd_en_l[w] = 1'b1;
    @(negedge clk);
    rd_en_l[w] = 1'b0;
    case (w)
      0:       begin d = a_rd_data; v = a_rd_valid; end
      1:       begin d = b_rd_data; v = b_rd_valid; end
      default: begin d = c_rd_data; v = c_rd_valid; end
    endcase
    @(negedge clk);
    case (w)
      0:       v_next = a_rd_valid;
      1:       v_next = b_rd_valid;
      default: v_next = c_rd_valid;
    endcase
  endtask

  logic [7:0] d;
  logic       v, vn;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_l[i]    = 1'b1;
      rd_en_l[i] = 1'b0;
    end
    repeat (5) @(negedge clk);

    // Reset values
    chk_eq("rst_rd_data", a_rd_data, 8'h00);
    chk_eq("rst_rd_valid", a_rd_valid, 1'b0);
    chk_eq("rst_empty", a_empty, 1'b1);
    chk_eq("rst_full", a_full, 1'b0);
    chk_eq("rst_count", a_count, 5'd0);
    chk_eq("rst_flags", {a_fe, a_pe, a_ov}, 3'b000);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame 0x5B
    send_frame(0, 8'h5B, -1, 1'b1);
    repeat (2) @(negedge clk);
    chk_eq("t1_count", a_count, 5'd1);
    chk_eq("t1_empty", a_empty, 1'b0);
    pop(0, d, v, vn);
    chk_eq("t1_rd_data", d, 8'h5B);
    chk_eq("t1_rd_valid", v, 1'b1);
    chk_eq("t1_rd_valid_pulse", vn, 1'b0);
    chk_eq("t1_empty_after", a_empty, 1'b1);

    // Pop on empty is ignored
    pop(0, d, v, vn);
    chk_eq("empty_pop_valid", v, 1'b0);
    chk_eq("empty_pop_count", a_count, 5'd0);

    // False start: 2000 ns low glitch
    rx_l[0] = 1'b0;
    #2000;
    rx_l[0] = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    chk_eq("fs_count", a_count, 5'd0);
    chk_eq("fs_flags", a_fe_n + a_pe_n + a_ov_n, 0);

    // Framing error, then recovery with 0xA5
    send_frame(0, 8'h5B, -1, 1'b0);
    repeat (2) @(negedge clk);
    chk_eq("fe_pulses", a_fe_n, 1);
    chk_eq("fe_count", a_count, 5'd0);
    send_frame(0, 8'hA5, -1, 1'b1);
    pop(0, d, v, vn);
    chk_eq("fe_next_data", d, 8'hA5);
    chk_eq("fe_next_valid", v, 1'b1);
    chk_eq("fe_no_extra_flags", a_fe_n * 16 + a_pe_n, 16);

    // Even parity: 0x5B has five ones, so parity bit must be 1
    send_frame(1, 8'h5B, 0, 1'b1);
    repeat (2) @(negedge clk);
    chk_eq("par_bad_pulse", b_pe_n, 1);
    chk_eq("par_bad_count", b_count, 5'd0);
    send_frame(1, 8'h5B, 1, 1'b1);
    repeat (2) @(negedge clk);
    chk_eq("par_good_count", b_count, 5'd1);
    chk_eq("par_good_pulses", b_pe_n * 16 + b_fe_n, 16);
    pop(1, d, v, vn);
    chk_eq("par_good_data", d, 8'h5B);

    // Depth-4 FIFO overflow
    for (int i = 1; i <= 4; i++) send_frame(2, 8'(i), -1, 1'b1);
    @(negedge clk);
    chk_eq("d4_full", c_full, 1'b1);
    chk_eq("d4_count", c_count, 3'd4);
    chk_eq("d4_no_ovf_yet", c_ov_n, 0);
    send_frame(2, 8'h05, -1, 1'b1);
    @(negedge clk);
    chk_eq("d4_ovf_pulse", c_ov_n, 1);
    chk_eq("d4_count_after_ovf", c_count, 3'd4);
    for (int i = 1; i <= 4; i++) begin
      pop(2, d, v, vn);
      chk_eq($sformatf("d4_rd_%0d", i), d, 8'(i));
    end
    chk_eq("d4_empty", c_empty, 1'b1);

    // Reset during data bit 3
    @(negedge clk);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rx_l[0] = 1'b1;
    #(BIT_NS / 2);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_rd_data", a_rd_data, 8'h00);
    chk_eq("mid_rst_rd_data_d4", c_rd_data, 8'h00);
    chk_eq("mid_rst_empty", a_empty, 1'b1);
    chk_eq("mid_rst_count", a_count, 5'd0);
    #(BIT_NS / 2);
    @(negedge clk);
    rst = 1'b0;
    #(2 * BIT_NS);
    @(negedge clk);
    chk_eq("post_rst_count", a_count, 5'd0);
    send_frame(0, 8'h3C, -1, 1'b1);
    pop(0, d, v, vn);
    chk_eq("post_rst_data", d, 8'h3C);
    chk_eq("post_rst_valid", v, 1'b1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // 0x5B with a short high glitch at the middle of data bit 2 (a 0 bit)
    @(negedge clk);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    rx_l[0] = 1'b0;
    #(BIT_NS / 2 - 200);
    rx_l[0] = 1'b1;
    #400;
    rx_l[0] = 1'b0;
    #(BIT_NS / 2 - 200);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    pop(0, d, v, vn);
    chk_eq("vote_glitch_data", d, 8'h5B);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
